// File: rtl/jk_bank_sched.sv
// Round-robin scheduler for a shared JK flip-flop bank: gnt, then J/K one cycle later, then done/rdata one cycle after that.
// Outputs are registered; a requester holds req/op/idx until gnt, and one command completes every 3 cycles.
module jk_bank_sched #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 rdata,
  output logic                 err,
  output logic [NBITS-1:0]     j_out,
  output logic [NBITS-1:0]     k_out,
  input  logic [NBITS-1:0]     q_in
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic [1:0]        op_l;
  logic [IDXW-1:0]   idx_l;
  logic [NBITS-1:0]  sel;
  logic [PW-1:0]     first_any, first_up, win_c;
  logic              up_found;
  logic [1:0]        op_c;
  logic [IDXW-1:0]   idx_c;

  // Descending scan: the last hit is the lowest index, both overall and at/above ptr.
  always_comb begin
    first_any = '0;
    first_up  = '0;
    up_found  = 1'b0;
    for (int c = NREQ - 1; c >= 0; c--) begin
      if (req[c]) begin
        first_any = PW'(c);
        if (c >= int'(ptr)) begin
          first_up = PW'(c);
          up_found = 1'b1;
        end
      end
    end
    win_c = up_found ? first_up : first_any;
  end

  always_comb begin
    op_c  = '0;
    idx_c = '0;
    for (int c = 0; c < NREQ; c++) begin
      if (PW'(c) == win_c) begin
        op_c  = op[2*c +: 2];
        idx_c = idx[IDXW*c +: IDXW];
      end
    end
  end

  // One-hot decode of the latched index; an out-of-range index decodes to all zeros.
  always_comb begin
    sel = '0;
    for (int b = 0; b < NBITS; b++) begin
      sel[b] = (idx_l == IDXW'(b));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ISSUE;
      ISSUE:   state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each output shows up the cycle after the state that produces it, so the bank
  // samples J/K at the end of the SETTLE cycle and q_in is updated while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      op_l  <= '0;
      idx_l <= '0;
      gnt   <= '0;
      done  <= '0;
      err   <= 1'b0;
      j_out <= '0;
      k_out <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= '0;
      done  <= '0;
      err   <= 1'b0;
      j_out <= '0;
      k_out <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            win   <= win_c;
            op_l  <= op_c;
            idx_l <= idx_c;
            gnt   <= NREQ'(1) << win_c;
            ptr   <= (win_c == PW'(NREQ - 1)) ? '0 : win_c + PW'(1);
          end
        end
        ISSUE: begin
          j_out <= op_l[1] ? sel : '0;
          k_out <= op_l[0] ? sel : '0;
        end
        SETTLE: begin
          done <= NREQ'(1) << win;
          err  <= ~(|sel);
        end
        default: ;
      endcase
    end
  end

  assign rdata = (|done) & (|(q_in & sel));

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: models the external JK bank, drives directed and random commands,
// and checks every cycle of each transaction against a transaction-level reference.
module tb_jk_bank_sched;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IW    = 4;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    op;
  logic [IW*NREQ-1:0]   idx;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 rdata;
  logic                 err;
  logic [NBITS-1:0]     j_out;
  logic [NBITS-1:0]     k_out;
  logic [NBITS-1:0]     q_in;
  logic [NBITS-1:0]     bank_q;

  int n_chk;
  int n_pass;
  int n_fail;

  logic [NBITS-1:0] mbits;
  int               mptr;

  jk_bank_sched #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .idx   (idx),
    .gnt   (gnt),
    .done  (done),
    .rdata (rdata),
    .err   (err),
    .j_out (j_out),
    .k_out (k_out),
    .q_in  (q_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External JK bank, reset from ~rst as the top level would wire it.
  always @(posedge clk) begin
    if (!(~rst)) begin
      bank_q <= '0;
    end else begin
      for (int b = 0; b < NBITS; b++) begin
        case ({j_out[b], k_out[b]})
          2'b01:   bank_q[b] <= 1'b0;
          2'b10:   bank_q[b] <= 1'b1;
          2'b11:   bank_q[b] <= ~bank_q[b];
          default: bank_q[b] <= bank_q[b];
        endcase
      end
    end
  end
  assign q_in = bank_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (m[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Called right after a negedge with the DUT idle; returns at the negedge where done is checked.
  task automatic do_txn(input logic [NREQ-1:0] m, input logic [2*NREQ-1:0] o,
                        input logic [IW*NREQ-1:0] x, input bit scr, input bit abort);
    int               w;
    int               wx;
    logic [1:0]       wo;
    logic [NBITS-1:0] ej, ek;
    logic             exp_rd;
    req = m;
    op  = o;
    idx = x;
    w   = pick(m, mptr);
    wo  = o[2*w +: 2];
    wx  = int'(x[IW*w +: IW]);
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(1) << w);
    chk("done_at_gnt", 32'(done), 32'd0);
    chk("jk_at_gnt", 32'(j_out | k_out), 32'd0);
    if (scr) begin
      req = NREQ'($urandom);
      op  = ~o;
      idx = (IW*NREQ)'($urandom);
    end
    mptr = (w + 1) % NREQ;
    ej = '0;
    ek = '0;
    if (wx < NBITS) begin
      ej[wx] = wo[1];
      ek[wx] = wo[0];
    end
    @(negedge clk);
    chk("j_issue", 32'(j_out), 32'(ej));
    chk("k_issue", 32'(k_out), 32'(ek));
    chk("gnt_issue", 32'(gnt), 32'd0);
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_err", 32'(err), 32'd0);
      chk("abort_jk", 32'(j_out | k_out), 32'd0);
      chk("abort_bank", 32'(q_in), 32'd0);
      rst   = 1'b0;
      mptr  = 0;
      mbits = '0;
      return;
    end
    if (scr) req = NREQ'($urandom);
    if (wx < NBITS) begin
      case (wo)
        2'b01:   mbits[wx] = 1'b0;
        2'b10:   mbits[wx] = 1'b1;
        2'b11:   mbits[wx] = ~mbits[wx];
        default: ;
      endcase
    end
    exp_rd = (wx < NBITS) ? mbits[wx] : 1'b0;
    @(negedge clk);
    chk("done", 32'(done), 32'(1) << w);
    chk("err", 32'(err), (wx >= NBITS) ? 32'd1 : 32'd0);
    chk("rdata", 32'(rdata), 32'(exp_rd));
    chk("bank", 32'(q_in), 32'(mbits));
    chk("jk_idle", 32'(j_out | k_out), 32'd0);
    chk("gnt_done", 32'(gnt), 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0]    m;
    logic [2*NREQ-1:0]  o;
    logic [IW*NREQ-1:0] x;
    n_chk = 0;
    n_pass = 0;
    n_fail = 0;
    mbits = '0;
    mptr  = 0;
    rst = 1'b1;
    req = '0;
    op  = '0;
    idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_jk", 32'(j_out | k_out), 32'd0);
    rst = 1'b0;

    // Set bit 5 from requester 0.
    do_txn(4'b0001, 8'b0000_0010, 16'h0005, 1'b0, 1'b0);
    // Toggle bit 5 twice from requester 2.
    do_txn(4'b0100, 8'b0011_0000, 16'h0500, 1'b0, 1'b0);
    do_txn(4'b0100, 8'b0011_0000, 16'h0500, 1'b0, 1'b0);
    // All requesters continuously asserted, each touching a different bit.
    for (int t = 0; t < 12; t++) begin
      do_txn(4'b1111, 8'b1111_1111, 16'h6420, 1'b0, 1'b0);
    end
    // Out-of-range index from requester 1.
    do_txn(4'b0010, 8'b0000_1000, 16'h0090, 1'b0, 1'b0);
    // Reset during the J/K cycle of a set on bit 3, then a full request set.
    do_txn(4'b0100, 8'b0010_0000, 16'h0300, 1'b0, 1'b1);
    do_txn(4'b1111, 8'b1010_1010, 16'h3210, 1'b0, 1'b0);
    // Opcode flips to clear right after grant; the latched set must still win.
    do_txn(4'b0001, 8'b0000_0010, 16'h0007, 1'b1, 1'b0);

    for (int t = 0; t < 200; t++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      o = (2*NREQ)'($urandom);
      for (int r = 0; r < NREQ; r++) x[IW*r +: IW] = IW'($urandom_range(0, 9));
      do_txn(m, o, x, 1'($urandom), $urandom_range(0, 24) == 0);
    end

    req = '0;
    repeat (2) @(negedge clk);
    chk("final_idle_gnt", 32'(gnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jk_bank_sched.md
Name: jk_bank_sched

Overview:
- Round-robin scheduler that shares one bank of NBITS JK flip-flops between NREQ requesters.
- Each requester issues one command per transaction: read, clear, set or toggle one flip-flop.
- The block serializes commands, drives the bank's J/K lines for exactly one cycle, then returns the resulting Q bit.
- Sits between the requester logic and an external array of JK flip-flop instances. The top level drives the bank's active-low reset from ~rst.

Parameters:
NREQ, 4, number of requesters (2..8)
NBITS, 8, number of JK flip-flops in the bank
IDXW, 3, flip-flop index width; must satisfy 2**IDXW >= NBITS

Ports:
clk    input   1            clock; all logic on posedge
rst    input   1            synchronous reset, active-high
req    input   NREQ         per-requester request level
op     input   2*NREQ       per-requester opcode, requester i at [2i+1:2i]: 00 read, 01 clear, 10 set, 11 toggle
idx    input   IDXW*NREQ    per-requester target index, requester i at [IDXW*i+IDXW-1:IDXW*i]
gnt    output  NREQ         one-hot grant pulse, 1 cycle
done   output  NREQ         one-hot completion pulse, 1 cycle
rdata  output  1            Q of the target bit after the command; valid while done is high
err    output  1            pulses with done when idx >= NBITS
j_out  output  NBITS        J lines to the bank
k_out  output  NBITS        K lines to the bank
q_in   input   NBITS        Q lines from the bank

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; gnt, done, rdata, err, j_out and k_out all 0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
- State IDLE:
  - If any req bit is 1, select the first set bit searching from pointer upward with wrap-around.
  - Latch that requester's op and idx, register the winner, pulse gnt[winner] for 1 cycle.
  - Set pointer = (winner+1) mod NREQ and go to ISSUE.
  - If no req bit is 1, stay in IDLE; pointer unchanged.
- State ISSUE (exactly 1 cycle):
  - Drive j_out[idx]/k_out[idx] from the latched op: read 0/0, clear 0/1, set 1/0, toggle 1/1.
  - All other j_out/k_out bits are 0.
  - If idx >= NBITS, drive all J/K bits to 0.
  - Go to SETTLE.
- State SETTLE (1 cycle):
  - j_out and k_out are all 0; the bank has sampled J/K at the ISSUE→SETTLE edge.
  - Sample q_in[idx] into rdata, or 0 if idx >= NBITS.
  - Pulse done[winner], and pulse err if idx >= NBITS. Go to IDLE.
- Latency and throughput:
  - gnt is visible the cycle after req is seen in IDLE; done follows 2 cycles after gnt.
  - Back-to-back throughput is one command per 3 cycles.
- Handshake:
  - A requester holds req, op and idx stable until it sees gnt.
  - op and idx are sampled only at the IDLE→ISSUE edge; later changes do not affect the transaction in flight.
  - A requester that keeps req high after done re-enters arbitration, at the lowest priority under round-robin.
- Fairness: with all NREQ requesters asserted continuously, grants rotate 0,1,...,NREQ-1,0; no starvation.
- Simultaneous events: req changes during ISSUE or SETTLE are ignored until the next IDLE cycle.
- Reset mid-operation:
  - rst in ISSUE or SETTLE aborts the transaction with no done and no err.
  - J/K return to 0 on that edge and pointer returns to 0.
  - The bank itself is cleared by its own reset.
- Invariants:
  - At most one bit of j_out|k_out is nonzero, and only in ISSUE.
  - gnt and done are each one-hot or zero, and are never high in the same cycle.

Test Plan:
- Reset, then req=0001, op0=10 (set), idx0=5 → gnt=0001 at cycle 1; j_out=0x20, k_out=0 at cycle 2; done=0001, rdata=1 at cycle 3; q_in[5] stays 1 afterwards.
- Toggle bit 5 twice from requester 2 (op=11, idx=5) → rdata=0, then rdata=1; other bits unchanged; j_out=k_out=0x20 only in the ISSUE cycles.
- req=1111 held for 12 transactions → gnt order 0,1,2,3,0,1,2,3,0,1,2,3; each done matches the preceding gnt; one command per 3 cycles.
- Requester 1 with idx=9 (NBITS=8), op=10 → j_out=k_out=0 throughout; done=0010 with err=1 and rdata=0.
- Assert rst in the ISSUE cycle of a set on bit 3 → no done or err; j_out=0 on the next cycle; the next grant goes to requester 0 if req=1111.
- Change op0 from 10 to 01 the cycle after gnt → the set still executes and rdata=1.
